// File: rtl/parity_uart_rx.sv
// parity_uart_rx: serial receiver deframing start/data/parity/stop with XOR parity check
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   rx         serial line, idles high, asynchronous to clk
//   data_out   last received data word (LSB received first)
//   valid      1-cycle pulse when data_out and error flags update
//   parity_err parity mismatch on last frame, held until next valid
//   frame_err  stop bit sampled low on last frame, held until next valid
//   busy       high whenever the receiver is not idle
module parity_uart_rx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int ODD_PARITY   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  output logic [DATA_W-1:0] data_out,
  output logic              valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = DATA_W > 1 ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST = BW'(DATA_W - 1);
  localparam logic OP = (ODD_PARITY != 0);
  localparam logic [2:0] IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PARITY = 3'd3, STOP = 3'd4, WAIT_HI = 3'd5;
  logic [2:0] state;
  logic [CW-1:0] cnt;
  logic [BW-1:0] bit_idx;
  logic [DATA_W-1:0] shift;
  logic s1, s2, perr;
  assign busy = state != IDLE;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      state <= IDLE;
      cnt <= '0;
      bit_idx <= '0;
      shift <= '0;
      perr <= 1'b0;
      data_out <= '0;
      valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      s1 <= rx;
      s2 <= s1;
      valid <= 1'b0;
      case (state)
        IDLE: if (!s2) begin
          state <= START;
          cnt <= '0;
        end
        START: if (cnt == HALF) begin
          cnt <= '0;
          bit_idx <= '0;
          state <= s2 ? IDLE : DATA;
        end else cnt <= cnt + 1'b1;
        DATA: if (cnt == FULL) begin
          cnt <= '0;
          shift[bit_idx] <= s2;
          bit_idx <= bit_idx + 1'b1;
          if (bit_idx == LAST) state <= PARITY;
        end else cnt <= cnt + 1'b1;
        PARITY: if (cnt == FULL) begin
          cnt <= '0;
          perr <= ^shift ^ s2 ^ OP;
          state <= STOP;
        end else cnt <= cnt + 1'b1;
        STOP: if (cnt == FULL) begin
          cnt <= '0;
          valid <= 1'b1;
          data_out <= shift;
          parity_err <= perr;
          frame_err <= ~s2;
          // a low stop bit may be a break; wait for the line to recover first
          state <= s2 ? IDLE : WAIT_HI;
        end else cnt <= cnt + 1'b1;
        WAIT_HI: if (s2) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_parity_uart_rx.sv
// tb_parity_uart_rx: directed self-checking bench for parity_uart_rx
module tb_parity_uart_rx;
  localparam int CPB = 16;
  logic clk = 1'b0, rst = 1'b1, rx = 1'b1;
  logic [7:0] data_out;
  logic valid, parity_err, frame_err, busy;
  int cmp = 0, errs = 0, vcnt = 0;
  logic [7:0] log_d [0:63];
  logic log_p [0:63];
  logic log_f [0:63];
  parity_uart_rx #(.DATA_W(8), .CLKS_PER_BIT(CPB), .ODD_PARITY(0)) dut (
    .clk(clk), .rst(rst), .rx(rx), .data_out(data_out), .valid(valid),
    .parity_err(parity_err), .frame_err(frame_err), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (valid) begin
    log_d[vcnt[5:0]] <= data_out;
    log_p[vcnt[5:0]] <= parity_err;
    log_f[vcnt[5:0]] <= frame_err;
    vcnt <= vcnt + 1;
  end
  task automatic send_bit(input logic b);
    rx = b;
    repeat (CPB) @(negedge clk);
  endtask
  task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(p);
    send_bit(s);
  endtask
  task automatic chk_frame(input string name, input int n0, input logic [7:0] d, input logic p, input logic f);
    @(negedge clk);
    cmp++; if (vcnt !== n0 + 1) begin errs++; $display("FAIL %s valid count: got %0d want %0d", name, vcnt - n0, 1); end
    cmp++; if (log_d[n0[5:0]] !== d) begin errs++; $display("FAIL %s data: got %h want %h", name, log_d[n0[5:0]], d); end
    cmp++; if (log_p[n0[5:0]] !== p) begin errs++; $display("FAIL %s parity_err: got %b want %b", name, log_p[n0[5:0]], p); end
    cmp++; if (log_f[n0[5:0]] !== f) begin errs++; $display("FAIL %s frame_err: got %b want %b", name, log_f[n0[5:0]], f); end
  endtask
  task automatic test_reset;
    repeat (3) @(negedge clk);
    cmp++; if ({data_out, valid, parity_err, frame_err, busy} !== 12'h0) begin errs++; $display("FAIL reset outputs: got %h want 000", {data_out, valid, parity_err, frame_err, busy}); end
    rst = 1'b0;
    repeat (5) @(negedge clk);
    cmp++; if (busy !== 1'b0) begin errs++; $display("FAIL idle busy: got %b want 0", busy); end
  endtask
  task automatic test_good_frame;
    int n0 = vcnt;
    send_frame(8'hA5, 1'b0, 1'b1);
    chk_frame("good_A5", n0, 8'hA5, 1'b0, 1'b0);
    cmp++; if (busy !== 1'b0) begin errs++; $display("FAIL good_A5 busy: got %b want 0", busy); end
  endtask
  task automatic test_parity_err;
    int n0 = vcnt;
    send_frame(8'h01, 1'b0, 1'b1);
    chk_frame("perr_01", n0, 8'h01, 1'b1, 1'b0);
    repeat (20) @(negedge clk);
    cmp++; if (parity_err !== 1'b1 || data_out !== 8'h01) begin errs++; $display("FAIL perr hold: got %b/%h want 1/01", parity_err, data_out); end
    n0 = vcnt;
    send_frame(8'h03, 1'b0, 1'b1);
    chk_frame("clear_03", n0, 8'h03, 1'b0, 1'b0);
  endtask
  task automatic test_frame_err;
    int n0 = vcnt;
    send_frame(8'h3C, 1'b0, 1'b0);
    chk_frame("ferr_3C", n0, 8'h3C, 1'b0, 1'b1);
    repeat (100) @(negedge clk);
    cmp++; if (vcnt !== n0 + 1) begin errs++; $display("FAIL break extra valid: got %0d want %0d", vcnt - n0, 1); end
    cmp++; if (busy !== 1'b1) begin errs++; $display("FAIL break busy: got %b want 1", busy); end
    rx = 1'b1;
    repeat (10) @(negedge clk);
    cmp++; if (busy !== 1'b0) begin errs++; $display("FAIL break recover busy: got %b want 0", busy); end
    n0 = vcnt;
    send_frame(8'h55, 1'b0, 1'b1);
    chk_frame("after_break_55", n0, 8'h55, 1'b0, 1'b0);
  endtask
  task automatic test_glitch;
    int n0 = vcnt;
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    cmp++; if (busy !== 1'b1) begin errs++; $display("FAIL glitch busy start: got %b want 1", busy); end
    repeat (10) @(negedge clk);
    cmp++; if (busy !== 1'b0) begin errs++; $display("FAIL glitch busy end: got %b want 0", busy); end
    repeat (200) @(negedge clk);
    cmp++; if (vcnt !== n0) begin errs++; $display("FAIL glitch valid: got %0d want 0", vcnt - n0); end
    cmp++; if (data_out !== 8'h55) begin errs++; $display("FAIL glitch data hold: got %h want 55", data_out); end
  endtask
  task automatic test_mid_reset;
    logic [7:0] d = 8'hF1;
    int n0 = vcnt;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(d[i]);
    rx = 1'b1;
    repeat (4) @(negedge clk);
    cmp++; if (busy !== 1'b1) begin errs++; $display("FAIL mid frame busy: got %b want 1", busy); end
    rst = 1'b1;
    #1;
    cmp++; if ({data_out, valid, parity_err, frame_err, busy} !== 12'h0) begin errs++; $display("FAIL async reset outputs: got %h want 000", {data_out, valid, parity_err, frame_err, busy}); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (9) @(negedge clk);
    for (int i = 5; i < 8; i++) send_bit(d[i]);
    send_bit(1'b1);
    send_bit(1'b1);
    repeat (200) @(negedge clk);
    cmp++; if (vcnt !== n0) begin errs++; $display("FAIL stale frame valid: got %0d want 0", vcnt - n0); end
    send_frame(8'hFF, 1'b0, 1'b1);
    chk_frame("after_rst_FF", n0, 8'hFF, 1'b0, 1'b0);
  endtask
  task automatic test_back_to_back;
    int n0 = vcnt;
    send_frame(8'h00, 1'b0, 1'b1);
    send_frame(8'h80, 1'b1, 1'b1);
    send_frame(8'h7E, 1'b0, 1'b1);
    repeat (5) @(negedge clk);
    cmp++; if (vcnt !== n0 + 3) begin errs++; $display("FAIL b2b count: got %0d want 3", vcnt - n0); end
    cmp++; if (log_d[n0[5:0]] !== 8'h00) begin errs++; $display("FAIL b2b data0: got %h want 00", log_d[n0[5:0]]); end
    cmp++; if (log_d[6'(n0 + 1)] !== 8'h80) begin errs++; $display("FAIL b2b data1: got %h want 80", log_d[6'(n0 + 1)]); end
    cmp++; if (log_d[6'(n0 + 2)] !== 8'h7E) begin errs++; $display("FAIL b2b data2: got %h want 7e", log_d[6'(n0 + 2)]); end
    cmp++; if ({log_p[n0[5:0]], log_p[6'(n0 + 1)], log_p[6'(n0 + 2)], log_f[n0[5:0]], log_f[6'(n0 + 1)], log_f[6'(n0 + 2)]} !== 6'b0) begin errs++; $display("FAIL b2b flags: got %b%b%b %b%b%b want 000 000", log_p[n0[5:0]], log_p[6'(n0 + 1)], log_p[6'(n0 + 2)], log_f[n0[5:0]], log_f[6'(n0 + 1)], log_f[6'(n0 + 2)]); end
    cmp++; if (busy !== 1'b0) begin errs++; $display("FAIL b2b busy: got %b want 0", busy); end
  endtask
  initial begin
    test_reset;
    test_good_frame;
    test_parity_err;
    test_frame_err;
    test_glitch;
    test_mid_reset;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end
endmodule
